// File: rtl/mem_stage.sv
// mem_stage: MIPS32 memory-access stage with the MEM/WB pipeline register.
// Owns a byte-addressable, word-organised data memory with byte/half/word
// stores, sign/zero-extended loads, alignment checking, a halt (freeze)
// input and a combinational word-indexed debug read port.
module mem_stage #(
    parameter  int BUS_WIDTH      = 32,
    parameter  int MEM_DEPTH      = 256,
    parameter  int REG_ADDR_WIDTH = 5,
    localparam int IDX_W          = $clog2(MEM_DEPTH)
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_halt,
    input  logic                      i_mem_read,
    input  logic                      i_mem_write,
    input  logic [1:0]                i_mem_width,
    input  logic                      i_unsigned,
    input  logic                      i_mem_to_reg,
    input  logic                      i_reg_write,
    input  logic [BUS_WIDTH-1:0]      i_alu_result,
    input  logic [BUS_WIDTH-1:0]      i_store_data,
    input  logic [REG_ADDR_WIDTH-1:0] i_rd,
    input  logic [IDX_W-1:0]          i_dbg_addr,
    output logic                      o_mem_to_reg,
    output logic                      o_reg_write,
    output logic [REG_ADDR_WIDTH-1:0] o_rd,
    output logic [BUS_WIDTH-1:0]      o_alu_result,
    output logic [BUS_WIDTH-1:0]      o_mem_result,
    output logic                      o_misaligned,
    output logic [BUS_WIDTH-1:0]      o_dbg_data
);

    typedef enum logic [1:0] {
        W_BYTE = 2'b00,
        W_HALF = 2'b01,
        W_RSVD = 2'b10,   // decoded as a word access
        W_WORD = 2'b11
    } width_e;

    typedef struct packed {
        logic                      mem_to_reg;
        logic                      reg_write;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [BUS_WIDTH-1:0]      alu_result;
        logic [BUS_WIDTH-1:0]      mem_result;
        logic                      misaligned;
    } mem_wb_t;

    logic [BUS_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic [IDX_W-1:0]     word_idx;
    logic [1:0]           lane;
    logic                 misaligned;
    logic [3:0]           lane_en;
    logic [BUS_WIDTH-1:0] rd_word;
    logic [BUS_WIDTH-1:0] wr_data;
    logic [BUS_WIDTH-1:0] wr_mask;
    logic [BUS_WIDTH-1:0] merged_word;
    logic [BUS_WIDTH-1:0] load_ext;
    logic [7:0]           byte_v;
    logic [15:0]          half_v;
    logic                 store_en;

    mem_wb_t wb_d, wb_q;

    // Address decode, alignment check, lane selection, load extension and store merge.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        word_idx   = i_alu_result[IDX_W+1:2];
        lane       = i_alu_result[1:0];
        rd_word    = mem_q[word_idx];
        misaligned = 1'b0;
        lane_en    = 4'b1111;
        wr_data    = i_store_data;
        byte_v     = rd_word[{lane, 3'b000} +: 8];
        half_v     = rd_word[{lane[1], 4'b0000} +: 16];
        load_ext   = rd_word;

        case (width_e'(i_mem_width))
            W_BYTE: begin
                lane_en  = 4'b0001 << lane;
                wr_data  = {4{i_store_data[7:0]}};
                load_ext = i_unsigned ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
            end
            W_HALF: begin
                misaligned = lane[0];
                lane_en    = lane[1] ? 4'b1100 : 4'b0011;
                wr_data    = {2{i_store_data[15:0]}};
                load_ext   = i_unsigned ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
            end
            default: begin
                misaligned = |lane;
            end
        endcase

        wr_mask     = {{8{lane_en[3]}}, {8{lane_en[2]}}, {8{lane_en[1]}}, {8{lane_en[0]}}};
        merged_word = (rd_word & ~wr_mask) | (wr_data & wr_mask);
        store_en    = i_mem_write & ~misaligned & ~i_halt;

        wb_d.mem_to_reg = i_mem_to_reg;
        wb_d.reg_write  = i_reg_write & ~(i_mem_read & misaligned);
        wb_d.rd         = i_rd;
        wb_d.alu_result = i_alu_result;
        wb_d.mem_result = (i_mem_read & ~misaligned) ? load_ext : '0;
        wb_d.misaligned = (i_mem_read | i_mem_write) & misaligned;
    end

    // Data memory: synchronous clear on reset, read-modify-write of the addressed word on store.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            // NOTE: the whole array is cleared on reset because software relies
            // on zeroed data memory; this keeps it out of a plain RAM macro.
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (store_en) begin
            // NOTE: non-blocking so the load path sees pre-write contents this cycle.
            mem_q[word_idx] <= merged_word;
        end
    end

    // MEM/WB pipeline register: cleared on reset, frozen while halted.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wb_q <= '0;
        end else if (!i_halt) begin
            wb_q <= wb_d;
        end
    end

    assign o_mem_to_reg = wb_q.mem_to_reg;
    assign o_reg_write  = wb_q.reg_write;
    assign o_rd         = wb_q.rd;
    assign o_alu_result = wb_q.alu_result;
    assign o_mem_result = wb_q.mem_result;
    assign o_misaligned = wb_q.misaligned;
    assign o_dbg_data   = mem_q[i_dbg_addr];

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed test-plan steps followed by randomized traffic, all
// checked against a byte-array reference model of the data memory.
module tb_mem_stage;

    localparam int DEPTH  = 256;
    localparam int NBYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        i_reset = 1'b0, i_halt = 1'b0, i_mem_read = 1'b0, i_mem_write = 1'b0;
    logic [1:0]  i_mem_width = 2'b00;
    logic        i_unsigned = 1'b0, i_mem_to_reg = 1'b0, i_reg_write = 1'b0;
    logic [31:0] i_alu_result = '0, i_store_data = '0;
    logic [4:0]  i_rd = '0;
    logic [7:0]  i_dbg_addr = '0;
    logic        o_mem_to_reg, o_reg_write, o_misaligned;
    logic [4:0]  o_rd;
    logic [31:0] o_alu_result, o_mem_result, o_dbg_data;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: memory as plain bytes, plus expected WB outputs.
    logic [7:0]  mem_b [NBYTES];
    logic        e_m2r, e_rw, e_mis;
    logic [4:0]  e_rd;
    logic [31:0] e_alu, e_res;

    always #5 clk = ~clk;

    mem_stage dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_halt       (i_halt),
        .i_mem_read   (i_mem_read),
        .i_mem_write  (i_mem_write),
        .i_mem_width  (i_mem_width),
        .i_unsigned   (i_unsigned),
        .i_mem_to_reg (i_mem_to_reg),
        .i_reg_write  (i_reg_write),
        .i_alu_result (i_alu_result),
        .i_store_data (i_store_data),
        .i_rd         (i_rd),
        .i_dbg_addr   (i_dbg_addr),
        .o_mem_to_reg (o_mem_to_reg),
        .o_reg_write  (o_reg_write),
        .o_rd         (o_rd),
        .o_alu_result (o_alu_result),
        .o_mem_result (o_mem_result),
        .o_misaligned (o_misaligned),
        .o_dbg_data   (o_dbg_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input int idx);
        int b;
        b = idx * 4;
        return {mem_b[b+3], mem_b[b+2], mem_b[b+1], mem_b[b]};
    endfunction

    // Drive one cycle of inputs, predict its effect, clock it, and compare everything.
    task automatic step(input logic rst, input logic halt, input logic rd, input logic wr,
                        input logic [1:0] w, input logic uns, input logic m2r, input logic rw,
                        input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rdi);
        int    a, size;
        bit    mis;
        longint val;
        @(negedge clk);
        i_reset = rst; i_halt = halt; i_mem_read = rd; i_mem_write = wr;
        i_mem_width = w; i_unsigned = uns; i_mem_to_reg = m2r; i_reg_write = rw;
        i_alu_result = alu; i_store_data = sd; i_rd = rdi;

        a    = int'(alu % NBYTES);
        size = (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
        mis  = (a % size) != 0;
        val  = 0;
        for (int k = 0; k < size; k++) val += longint'(mem_b[a+k]) << (8 * k);
        if (!uns && size < 4 && val >= (longint'(1) << (8 * size - 1)))
            val -= (longint'(1) << (8 * size));

        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < NBYTES; i++) mem_b[i] = 8'h00;
            {e_m2r, e_rw, e_rd, e_alu, e_res, e_mis} = '0;
        end else if (!halt) begin
            e_m2r = m2r;
            e_rw  = rw && !(rd && mis);
            e_rd  = rdi;
            e_alu = alu;
            e_res = (rd && !mis) ? 32'(val) : 32'h0;
            e_mis = (rd || wr) && mis;
            if (wr && !mis)
                for (int k = 0; k < size; k++) mem_b[a+k] = 8'(sd >> (8 * k));
        end

        check("mem_to_reg", 32'(o_mem_to_reg), 32'(e_m2r));
        check("reg_write",  32'(o_reg_write),  32'(e_rw));
        check("rd",         32'(o_rd),         32'(e_rd));
        check("alu_result", o_alu_result,      e_alu);
        check("mem_result", o_mem_result,      e_res);
        check("misaligned", 32'(o_misaligned), 32'(e_mis));
        check("dbg_data",   o_dbg_data,        model_word(int'(i_dbg_addr)));
    endtask

    initial begin
        for (int i = 0; i < NBYTES; i++) mem_b[i] = 8'h00;

        // Reset held two cycles with a store pending.
        i_dbg_addr = 8'd4;
        step(1, 0, 0, 1, 2'b11, 0, 1, 1, 32'h10, 32'hDEADBEEF, 5'd3);
        step(1, 0, 0, 1, 2'b11, 0, 1, 1, 32'h10, 32'hDEADBEEF, 5'd3);
        check("reset_dbg4", o_dbg_data, 32'h0);
        check("reset_res", o_mem_result, 32'h0);

        // Word store, then load of the same word in the next cycle.
        i_dbg_addr = 8'd8;
        step(0, 0, 0, 1, 2'b11, 0, 0, 0, 32'h20, 32'h87654321, 5'd0);
        step(0, 0, 1, 0, 2'b11, 0, 1, 1, 32'h20, 32'h0, 5'd2);
        check("load_word", o_mem_result, 32'h87654321);
        step(0, 0, 0, 0, 2'b11, 0, 0, 1, 32'h12345678, 32'h0, 5'd7);
        check("pass_alu", o_alu_result, 32'h12345678);
        check("pass_rd", 32'(o_rd), 32'd7);
        check("pass_rw", 32'(o_reg_write), 32'd1);

        // Byte and half extension.
        step(0, 0, 1, 0, 2'b00, 0, 1, 1, 32'h23, 32'h0, 5'd1);
        check("lb_signed", o_mem_result, 32'hFFFFFF87);
        step(0, 0, 1, 0, 2'b00, 1, 1, 1, 32'h23, 32'h0, 5'd1);
        check("lbu", o_mem_result, 32'h00000087);
        step(0, 0, 1, 0, 2'b01, 0, 1, 1, 32'h20, 32'h0, 5'd1);
        check("lh_signed", o_mem_result, 32'h00004321);

        // Narrow stores.
        step(0, 0, 0, 1, 2'b00, 0, 0, 0, 32'h21, 32'h123456AB, 5'd0);
        check("sb_dbg", o_dbg_data, 32'h8765AB21);
        step(0, 0, 0, 1, 2'b01, 0, 0, 0, 32'h22, 32'h1234CAFE, 5'd0);
        check("sh_dbg", o_dbg_data, 32'hCAFEAB21);

        // Misaligned accesses.
        step(0, 0, 0, 1, 2'b11, 0, 0, 0, 32'h22, 32'hFFFFFFFF, 5'd0);
        check("mis_sw_dbg", o_dbg_data, 32'hCAFEAB21);
        check("mis_sw_flag", 32'(o_misaligned), 32'd1);
        step(0, 0, 1, 0, 2'b01, 0, 1, 1, 32'h21, 32'h0, 5'd9);
        check("mis_lh_res", o_mem_result, 32'h0);
        check("mis_lh_rw", 32'(o_reg_write), 32'd0);

        // Halt for three cycles with a store presented; then an address that wraps.
        i_dbg_addr = 8'd12;
        for (int c = 0; c < 3; c++)
            step(0, 1, 0, 1, 2'b11, 0, 1, 1, 32'h30, 32'h55AA55AA, 5'd4);
        check("halt_dbg", o_dbg_data, 32'h0);
        check("halt_rd_hold", 32'(o_rd), 32'd9);
        i_dbg_addr = 8'd1;
        step(0, 0, 0, 1, 2'b11, 0, 0, 0, DEPTH * 4 + 32'h04, 32'h11223344, 5'd0);
        check("wrap_dbg1", o_dbg_data, 32'h11223344);

        // Randomized traffic over the first 16 words with random upper address bits.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] r;
            r = $urandom;
            i_dbg_addr = 8'($urandom_range(0, 15));
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
                 r[0], r[1], r[3:2], r[4], r[5], r[6],
                 $urandom & 32'hFFFFFC3F, $urandom, 5'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
